// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider.
//   div_state_t    : FSM state encoding (IDLE -> RUN -> FIX -> IDLE)
//   DIV_WIDTH_DEF  : default operand width
//   DIV_CNT_W_DEF  : iteration-counter width for the default operand width
//   div_cnt_w()    : iteration-counter width for any operand width (>= 2)
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH_DEF = 32;
    localparam int DIV_CNT_W_DEF = $clog2(DIV_WIDTH_DEF);

    // The counter must hold WIDTH-1; $clog2(WIDTH) bits are enough for that.
    function automatic int div_cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   r      in   WIDTH  partial remainder (magnitude)
//   q      in   WIDTH  quotient / dividend shift register
//   d      in   WIDTH  divisor magnitude
//   r_next out  WIDTH  partial remainder after this iteration
//   q_next out  WIDTH  quotient register after this iteration
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The remainder entering an iteration is always below 2^(WIDTH-1), so
    // the shifted value fits in WIDTH bits and bit WIDTH of the trial
    // difference is a true sign bit.
    // NOTE: combinational logic uses blocking assignments and gives every
    // output a value on every path, so no latch is inferred.
    always_comb begin
        shifted = {r, q[WIDTH-1]};
        trial   = shifted - {1'b0, d};
        if (!trial[WIDTH]) begin
            r_next = trial[WIDTH-1:0];
            q_next = {q[WIDTH-2:0], 1'b1};
        end else begin
            r_next = shifted[WIDTH-1:0];
            q_next = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_iterative.sv
// Sequential signed divider, one quotient bit per clock (restoring division
// on magnitudes followed by sign correction). hi = remainder, lo = quotient.
// Optional feature macro: DIV_ZERO_EN (adds div_zero and a 1-cycle
// divide-by-zero path).
// Ports:
//   clock      in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   start      in   1      request a division, sampled only while idle
//   operando1  in   WIDTH  dividend, signed
//   operando2  in   WIDTH  divisor, signed
//   hi         out  WIDTH  remainder, signed (sign of dividend)
//   lo         out  WIDTH  quotient, signed (truncated toward zero)
//   fim        out  1      1 = idle, results valid and held
//   div_zero   out  1      divide-by-zero flag (DIV_ZERO_EN builds only)
module div_iterative
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operando1,
    input  logic [WIDTH-1:0] operando2,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             fim
`ifdef DIV_ZERO_EN
    ,
    output logic             div_zero
`endif
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             sign_q;
    logic             sign_r;
    logic             skip_run;

    // Unsigned WIDTH-bit magnitudes: |-2^(WIDTH-1)| is representable.
    logic [WIDTH-1:0] abs_op1;
    logic [WIDTH-1:0] abs_op2;
    assign abs_op1 = operando1[WIDTH-1] ? -operando1 : operando1;
    assign abs_op2 = operando2[WIDTH-1] ? -operando2 : operando2;

`ifdef DIV_ZERO_EN
    logic zero_pend;
    assign skip_run = (operando2 == '0);
`else
    assign skip_run = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (rem),
        .q      (quo),
        .d      (dvs),
        .r_next (rem_next),
        .q_next (quo_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        fim        = 1'b0;
        case (state)
            IDLE: begin
                fim = 1'b1;
                if (start) state_next = skip_run ? FIX : RUN;
            end
            RUN:     if (count == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The whole datapath is reset so an aborted run leaves nothing behind.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count     <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            hi        <= '0;
            lo        <= '0;
`ifdef DIV_ZERO_EN
            zero_pend <= 1'b0;
            div_zero  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    sign_q    <= operando1[WIDTH-1] ^ operando2[WIDTH-1];
                    sign_r    <= operando1[WIDTH-1];
                    quo       <= abs_op1;
                    dvs       <= abs_op2;
                    rem       <= '0;
                    count     <= CNT_W'(WIDTH - 1);
`ifdef DIV_ZERO_EN
                    zero_pend <= skip_run;
                    div_zero  <= 1'b0;
`endif
                end
                RUN: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    if (count != '0) count <= count - CNT_W'(1);
                end
                FIX: begin
                    lo <= sign_q ? -quo : quo;
                    hi <= sign_r ? -rem : rem;
`ifdef DIV_ZERO_EN
                    // RUN was skipped, so quo still holds |dividend|.
                    if (zero_pend) begin
                        lo       <= '1;
                        hi       <= sign_r ? -quo : quo;
                        div_zero <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iterative.sv
// Self-checking bench for div_iterative (WIDTH = 32). Expected values come
// from directed constants and a 64-bit arithmetic reference model.
module tb_div_iterative;

    localparam int W = 32;

    logic         clock;
    logic         reset;
    logic         start;
    logic [W-1:0] operando1;
    logic [W-1:0] operando2;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         fim;
`ifdef DIV_ZERO_EN
    logic         div_zero;
`endif

    int total = 0;
    int bad   = 0;

    div_iterative #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .operando1 (operando1),
        .operando2 (operando2),
        .hi        (hi),
        .lo        (lo),
        .fim       (fim)
`ifdef DIV_ZERO_EN
        ,
        .div_zero  (div_zero)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: signed division in 64 bits (no overflow), truncating toward
    // zero, remainder with the dividend's sign; divide-by-zero per build.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
`ifdef DIV_ZERO_EN
            q = '1;
`else
            q = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
`endif
            r = a;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endfunction

    function automatic int exp_busy(input logic [W-1:0] b);
`ifdef DIV_ZERO_EN
        return (b == '0) ? 1 : W + 1;
`else
        return (b == '0) ? W + 1 : W + 1;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Launch one division from IDLE and wait for fim. busy counts the cycles
    // fim stayed low; held reports whether hi/lo stayed put while busy.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit keep_start, output int busy, output bit held);
        logic [W-1:0] prev_hi;
        logic [W-1:0] prev_lo;
        prev_hi   = hi;
        prev_lo   = lo;
        operando1 = a;
        operando2 = b;
        start     = 1'b1;
        tick();
        if (!keep_start) start = 1'b0;
        busy = 0;
        held = 1'b1;
        while (!fim && busy < 100) begin
            if (hi !== prev_hi || lo !== prev_lo) held = 1'b0;
            tick();
            busy++;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b0;
        operando1 = '0;
        operando2 = '0;
        #3;
        total++;
        if (hi !== '0 || lo !== '0 || fim !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: hi=%h lo=%h fim=%b, required hi=0 lo=0 fim=1", hi, lo, fim);
        end
`ifdef DIV_ZERO_EN
        total++;
        if (div_zero !== 1'b0) begin
            bad++;
            $display("FAIL reset_div_zero: got %b, required 0", div_zero);
        end
`endif
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [9];
        logic [W-1:0] tb [9];
        logic [W-1:0] tq [9];
        logic [W-1:0] tr [9];
        int  busy;
        bit  held;
        ta = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C, 32'h8000_0000,
               32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFB, 32'd9};
        tb = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
               32'd1, 32'd0, 32'd0, 32'd2};
        tq = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14, 32'h8000_0000,
               32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd4};
        tr = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFE, 32'd0,
               32'd0, 32'd5, 32'hFFFF_FFFB, 32'd1};
`ifdef DIV_ZERO_EN
        tq[7] = 32'hFFFF_FFFF;
`endif
        for (int i = 0; i < 9; i++) begin
            do_div(ta[i], tb[i], 1'b0, busy, held);
            total++;
            if (busy !== exp_busy(tb[i])) begin
                bad++;
                $display("FAIL dir_busy[%0d]: fim low %0d cycles, required %0d", i, busy, exp_busy(tb[i]));
            end
            total++;
            if (lo !== tq[i] || hi !== tr[i]) begin
                bad++;
                $display("FAIL dir_result[%0d] %h/%h: lo=%h hi=%h, required lo=%h hi=%h",
                         i, ta[i], tb[i], lo, hi, tq[i], tr[i]);
            end
            total++;
            if (!held) begin
                bad++;
                $display("FAIL dir_hold[%0d]: hi/lo changed before the result edge, required held", i);
            end
`ifdef DIV_ZERO_EN
            total++;
            if (div_zero !== (tb[i] == '0)) begin
                bad++;
                $display("FAIL dir_div_zero[%0d]: got %b, required %b", i, div_zero, tb[i] == '0);
            end
`endif
            tick();
        end
`ifdef DIV_ZERO_EN
        // Flag persists while idle and clears on the next accepted start.
        do_div(32'd5, 32'd0, 1'b0, busy, held);
        tick();
        tick();
        tick();
        total++;
        if (div_zero !== 1'b1) begin
            bad++;
            $display("FAIL div_zero_hold: got %b while idle, required 1", div_zero);
        end
        operando1 = 32'd9;
        operando2 = 32'd2;
        start     = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (div_zero !== 1'b0) begin
            bad++;
            $display("FAIL div_zero_clear: got %b after new start, required 0", div_zero);
        end
        busy = 0;
        while (!fim && busy < 100) begin
            tick();
            busy++;
        end
        tick();
`endif
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] prev_hi;
        logic [W-1:0] prev_lo;
        int  busy;
        bit  held;
        prev_hi   = hi;
        prev_lo   = lo;
        operando1 = 32'd100;
        operando2 = 32'd7;
        start     = 1'b1;
        tick();
        start = 1'b0;
        busy  = 0;
        held  = 1'b1;
        while (!fim && busy < 100) begin
            if (hi !== prev_hi || lo !== prev_lo) held = 1'b0;
            if (busy == 9) begin
                operando1 = 32'd1000;
                operando2 = 32'd3;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            busy++;
        end
        start = 1'b0;
        total++;
        if (busy !== W + 1) begin
            bad++;
            $display("FAIL busy_start_busy: fim low %0d cycles, required %0d", busy, W + 1);
        end
        total++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            bad++;
            $display("FAIL busy_start_result: lo=%h hi=%h, required lo=0000000e hi=00000002", lo, hi);
        end
        total++;
        if (!held) begin
            bad++;
            $display("FAIL busy_start_hold: hi/lo changed during run, required held");
        end
        tick();
        tick();
        total++;
        if (fim !== 1'b1) begin
            bad++;
            $display("FAIL busy_start_no_rerun: fim=%b after run, required 1", fim);
        end
    endtask

    task automatic test_reset_mid();
        int  busy;
        bit  held;
        do_div(32'd1000, 32'd7, 1'b0, busy, held);
        tick();
        operando1 = 32'd12345;
        operando2 = 32'd67;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        reset = 1'b1;
        #1;
        total++;
        if (hi !== '0 || lo !== '0 || fim !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: hi=%h lo=%h fim=%b, required hi=0 lo=0 fim=1", hi, lo, fim);
        end
        tick();
        reset = 1'b0;
        tick();
        do_div(32'd9, 32'd2, 1'b0, busy, held);
        total++;
        if (lo !== 32'd4 || hi !== 32'd1 || busy !== W + 1) begin
            bad++;
            $display("FAIL after_reset_9_2: lo=%h hi=%h busy=%0d, required lo=4 hi=1 busy=%0d",
                     lo, hi, busy, W + 1);
        end
        tick();
    endtask

    // start held high for the whole sequence: each result is followed by
    // exactly one idle cycle in which the next operands are accepted.
    task automatic test_back_to_back_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        longint sa, sb, sq, sr;
        int  busy;
        bit  held;
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 15))
                0:       begin a = $urandom; b = '0; end
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       begin a = $urandom; b = 32'h8000_0000; end
                3, 4:    begin a = $urandom; b = W'($signed($urandom_range(0, 30)) - 15); end
                5, 6:    begin a = W'($signed($urandom_range(0, 2000)) - 1000); b = $urandom; end
                default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            if ($urandom_range(0, 1) == 1) b = -b;
            ref_div(a, b, eq, er);
            do_div(a, b, 1'b1, busy, held);
            total++;
            if (lo !== eq || hi !== er) begin
                bad++;
                $display("FAIL rand[%0d] %h/%h: lo=%h hi=%h, required lo=%h hi=%h",
                         n, a, b, lo, hi, eq, er);
            end
            total++;
            if (busy !== exp_busy(b) || !held) begin
                bad++;
                $display("FAIL rand_timing[%0d]: busy=%0d held=%b, required busy=%0d held=1",
                         n, busy, held, exp_busy(b));
            end
            if (b != '0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                sq = longint'($signed(lo));
                sr = longint'($signed(hi));
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) sq = -sq;
                if (sa < 0) sa = -sa;
                if (sb < 0) sb = -sb;
                total++;
                if (sa != sb * (sq < 0 ? -sq : sq) + (sr < 0 ? -sr : sr)
                    || (sr < 0 ? -sr : sr) >= sb) begin
                    bad++;
                    $display("FAIL rand_identity[%0d] %h/%h: lo=%h hi=%h break |a|=|b||q|+|r|, |r|<|b|",
                             n, a, b, lo, hi);
                end
                total++;
                if (hi != '0 && hi[W-1] !== a[W-1]) begin
                    bad++;
                    $display("FAIL rand_rem_sign[%0d] %h/%h: hi=%h, required sign of dividend", n, a, b, hi);
                end
            end
        end
        start = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
